uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_sampler.sv | 65 ++++++
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// UART receiver shared types: FSM states and the legal oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    function automatic logic [5:0] legal_presc(input logic [5:0] p);
        logic [5:0] r;
        case (p)
            PRESC_8, PRESC_16, PRESC_32: r = p;
            default:                     r = PRESC_8;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Edge/bit counters and bit decision for uart_rx.
// UART_RX_MAJORITY_SAMPLE_EN selects a 3-sample vote instead of one mid sample.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int BW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          rx_in,
    input  logic          en,
    input  logic          bit_en,
    input  logic [5:0]    p,
    output logic [5:0]    edge_cnt,
    output logic [BW-1:0] bit_cnt,
    output logic          bit_val,
    output logic          bit_end
);

    logic [5:0] half;
    logic       s_mid;
    logic       vote;

    assign half    = p >> 1;
    assign bit_end = en && (edge_cnt == p - 6'd1);

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    logic s_lo;

    assign vote = (s_lo & s_mid) | (s_lo & rx_in) | (s_mid & rx_in);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            s_lo <= 1'b0;
        else if (en && edge_cnt == half - 6'd1)
            s_lo <= rx_in;
    end
`else
    assign vote = s_mid;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            s_mid    <= 1'b0;
            bit_val  <= 1'b0;
        end else begin
            if (!en || bit_end)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + 6'd1;
            if (!bit_en)
                bit_cnt <= '0;
            else if (bit_end)
                bit_cnt <= bit_cnt + BW'(1);
            if (en && edge_cnt == half)
                s_mid <= rx_in;
            // decision lands at P/2+1 in both builds
            if (en && edge_cnt == half + 6'd1)
                bit_val <= vote;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: frame FSM, shifter and parity check.
// Bit sampling rule chosen by UART_RX_MAJORITY_SAMPLE_EN (see uart_rx_sampler).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;

    state_t                state;
    logic [5:0]            p_lat;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  armed;
    logic                  perr;
    logic [DATA_WIDTH-1:0] shreg;
    logic [5:0]            edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  bit_val;
    logic                  bit_end;

    uart_rx_sampler #(.BW(BW)) u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .rx_in    (RX_IN),
        .en       (state != IDLE),
        .bit_en   (state == DATA),
        .p        (p_lat),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_val  (bit_val),
        .bit_end  (bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            p_lat      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            armed      <= 1'b0;
            perr       <= 1'b0;
            shreg      <= '0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            // a start needs the line seen high since reset
            if (RX_IN)
                armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (armed && !RX_IN) begin
                        state     <= START;
                        p_lat     <= legal_presc(Prescale);
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        perr      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end)
                        state <= bit_val ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
                        if (bit_cnt == BW'(DATA_WIDTH - 1))
                            state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        if (bit_val != (^shreg ^ par_typ_q)) begin
                            par_err <= 1'b1;
                            perr    <= 1'b1;
                        end
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!bit_val) begin
                            stp_err <= 1'b1;
                        end else if (!perr) begin
                            P_DATA     <= shreg;
                            data_valid <= 1'b1;
                        end
                        if (!RX_IN) begin
                            state     <= START;
                            p_lat     <= legal_presc(Prescale);
                            par_en_q  <= PAR_EN;
                            par_typ_q <= PAR_TYP;
                            perr      <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed table, corner sequences, random frames.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_dv = 0;
    int n_pe = 0;
    int n_se = 0;
    logic [7:0] dv_q[$];
    int dvc_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (data_valid) begin
            n_dv++;
            dv_q.push_back(P_DATA);
            dvc_q.push_back(cyc);
        end
        if (par_err) n_pe++;
        if (stp_err) n_se++;
    end

    typedef struct {
        logic [7:0] d;
        int         p;
        int         bp;
        bit         pe;
        bit         pt;
        bit         pbit;
        bit         stop;
        bit         dv;
        bit         perr;
        bit         serr;
        logic [7:0] pd;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // drive one frame starting at a negedge; gbit>=0 injects a 1-cycle glitch
    task automatic send_frame(input logic [7:0] d, input int bp, input bit pe,
                              input bit pbit, input bit stop, input int gbit,
                              output int c0);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pbit);
        bits.push_back(stop);
        c0 = cyc;
        for (int k = 0; k < bits.size(); k++) begin
            RX_IN = bits[k];
            if (k == gbit) begin
                repeat (bp / 2 + 1) @(negedge CLK);
                RX_IN = ~bits[k];
                @(negedge CLK);
                RX_IN = bits[k];
                repeat (bp - bp / 2 - 2) @(negedge CLK);
            end else begin
                repeat (bp) @(negedge CLK);
            end
        end
    endtask

    task automatic expect_frame(input string nm, input int dv0, input int pe0,
                                input int se0, input bit edv, input bit epe,
                                input bit ese, input logic [7:0] epd,
                                input int c0, input int lat);
        chk({nm, " dv"}, n_dv - dv0, int'(edv));
        chk({nm, " par_err"}, n_pe - pe0, int'(epe));
        chk({nm, " stp_err"}, n_se - se0, int'(ese));
        chk({nm, " P_DATA"}, int'(P_DATA), int'(epd));
        if (edv && n_dv > dv0)
            chk({nm, " latency"}, dvc_q[dvc_q.size() - 1] - (c0 + 1), lat);
    endtask

    function automatic int eff_p(input int p);
        return (p == 8 || p == 16 || p == 32) ? p : 8;
    endfunction

    initial begin
        int c0, c1, dv0, pe0, se0, q0;
        logic [7:0] model_pd;

        tbl[0] = '{8'hA5,  8,  8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        tbl[1] = '{8'h3C, 16, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
        tbl[2] = '{8'h3C, 16, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
        tbl[3] = '{8'h81, 32, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
        tbl[4] = '{8'h5A, 20,  8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
        tbl[5] = '{8'h07, 16, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07};
        tbl[6] = '{8'hC3,  0,  8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07};

        repeat (3) @(negedge CLK);
        chk("reset P_DATA", int'(P_DATA), 0);
        chk("reset strobes", int'({data_valid, par_err, stp_err}), 0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        foreach (tbl[i]) begin
            Prescale = 6'(tbl[i].p);
            PAR_EN   = tbl[i].pe;
            PAR_TYP  = tbl[i].pt;
            dv0 = n_dv; pe0 = n_pe; se0 = n_se;
            send_frame(tbl[i].d, tbl[i].bp, tbl[i].pe, tbl[i].pbit,
                       tbl[i].stop, -1, c0);
            RX_IN = 1'b1;
            repeat (4) @(negedge CLK);
            expect_frame($sformatf("tbl%0d", i), dv0, pe0, se0, tbl[i].dv,
                         tbl[i].perr, tbl[i].serr, tbl[i].pd, c0,
                         (tbl[i].pe ? 11 : 10) * tbl[i].bp);
            repeat (3) @(negedge CLK);
        end
        model_pd = 8'h07;

        // back-to-back frames, no idle gap
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        dv0 = n_dv; q0 = dv_q.size();
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, -1, c0);
        send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, -1, c1);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        chk("b2b count", n_dv - dv0, 2);
        if (dv_q.size() >= q0 + 2) begin
            chk("b2b first", int'(dv_q[q0]), 8'h12);
            chk("b2b second", int'(dv_q[q0 + 1]), 8'h34);
            chk("b2b spacing", dvc_q[q0 + 1] - dvc_q[q0], 80);
        end
        model_pd = 8'h34;
        repeat (3) @(negedge CLK);

        // start glitch: 3 low cycles must not start a frame
        Prescale = 6'd16;
        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (40) @(negedge CLK);
        expect_frame("glitch", dv0, pe0, se0, 1'b0, 1'b0, 1'b0, model_pd, 0, 0);
        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        send_frame(8'h99, 16, 1'b0, 1'b0, 1'b1, -1, c0);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        expect_frame("after glitch", dv0, pe0, se0, 1'b1, 1'b0, 1'b0, 8'h99, c0, 160);
        model_pd = 8'h99;
        repeat (3) @(negedge CLK);

`ifdef UART_RX_MAJORITY_SAMPLE_EN
        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, 3, c0);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        expect_frame("maj glitch", dv0, pe0, se0, 1'b1, 1'b0, 1'b0, 8'hFF, c0, 160);
        model_pd = 8'hFF;
        repeat (3) @(negedge CLK);
`endif

        // reset during data bit 4 (a 0 bit), line still low at release
        Prescale = 6'd8;
        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX_IN = (8'hE7 >> i) & 1'b1;
            repeat (8) @(negedge CLK);
        end
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("async rst P_DATA", int'(P_DATA), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (20) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (10) @(negedge CLK);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1, c0);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        expect_frame("post reset", dv0, pe0, se0, 1'b1, 1'b0, 1'b0, 8'h55, c0, 80);
        model_pd = 8'h55;
        repeat (3) @(negedge CLK);

        // random frames against the reference model
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            int  p, bp, sel;
            bit  pe, pt, pbit, stop, epe, ese, edv;
            d    = 8'($urandom);
            sel  = $urandom_range(0, 4);
            p    = (sel == 0) ? 8 : (sel == 1) ? 16 : (sel == 2) ? 32 :
                   (sel == 3) ? 13 : 40;
            bp   = eff_p(p);
            pe   = 1'($urandom_range(0, 1));
            pt   = 1'($urandom_range(0, 1));
            pbit = 1'(($countones(d) % 2) ^ int'(pt));
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            stop = ($urandom_range(0, 5) != 0);
            epe  = pe && (pbit != 1'(($countones(d) % 2) ^ int'(pt)));
            ese  = !stop;
            edv  = !epe && !ese;
            if (edv) model_pd = d;
            Prescale = 6'(p); PAR_EN = pe; PAR_TYP = pt;
            dv0 = n_dv; pe0 = n_pe; se0 = n_se;
            send_frame(d, bp, pe, pbit, stop, -1, c0);
            RX_IN = 1'b1;
            repeat (4) @(negedge CLK);
            expect_frame($sformatf("rnd%0d", n), dv0, pe0, se0, edv, epe, ese,
                         model_pd, c0, (pe ? 11 : 10) * bp);
            repeat ($urandom_range(1, 6)) @(negedge CLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
